// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the processing-core multiply path.
//   state_t      - multiplier FSM encoding (ST_IDLE, ST_CALC, ST_FIX, ST_DONE)
//   DATA_WIDTH   - default operand/result width, shared with the accumulator
package mult_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative signed shift-add multiplier feeding the accumulator.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request; sampled only in IDLE or DONE
//   op_a       in   signed multiplicand, captured on the accepted start edge
//   op_b       in   signed multiplier, captured on the accepted start edge
//   result     out  low DATA_WIDTH bits of the signed product
//   ovf        out  product does not fit in DATA_WIDTH signed bits
//   busy       out  high in CALC and FIX
//   done       out  one-cycle strobe in DONE (accumulator write enable)
//   dbg_state  out  current FSM state, for observation only
//
// Handshake: a request is taken on any rising edge where start=1 and the
// FSM is in IDLE or DONE; start is ignored in every other state. Each
// accepted request produces exactly one done pulse unless rst intervenes,
// and result/ovf are valid whenever done is high and stay put until the
// next accepted request.
module seq_multiplier #(
    parameter int DATA_WIDTH = mult_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done,
    output mult_pkg::state_t      dbg_state
);
    import mult_pkg::*;

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_mag_q, a_mag_d;   // |op_a|, unsigned
    logic [W-1:0]     b_q, b_d;           // |op_b|, shifted right each iteration
    logic             sign_q, sign_d;
    logic [2*W-1:0]   prod_q, prod_d;     // unsigned magnitude partial product
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     result_q, result_d;
    logic             ovf_q, ovf_d;

    // Magnitudes: negating -2^(W-1) yields 2^(W-1), which is exactly
    // representable as a W-bit unsigned value.
    logic [W-1:0]     a_abs, b_abs;
    logic [2*W-1:0]   addend;
    logic [2*W-1:0]   prod_signed;
    logic [W:0]       prod_upper;
    logic             ovf_fix;

    assign a_abs       = op_a[W-1] ? -op_a : op_a;
    assign b_abs       = op_b[W-1] ? -op_b : op_b;
    assign addend      = {{W{1'b0}}, a_mag_q} << cnt_q;
    assign prod_signed = sign_q ? -prod_q : prod_q;
    // The product fits in W signed bits only if bits [2W-1:W-1] are a pure
    // sign extension.
    assign prod_upper  = prod_signed[2*W-1:W-1];
    assign ovf_fix     = !((&prod_upper) || !(|prod_upper));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_mag_q  <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_mag_q  <= a_mag_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_mag_d  = a_mag_q;
        b_d      = b_q;
        sign_d   = sign_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_mag_d = a_abs;
                    b_d     = b_abs;
                    sign_d  = op_a[W-1] ^ op_b[W-1];
                    prod_d  = '0;
                    cnt_d   = '0;
                    if ((op_a == '0) || (op_b == '0)) begin
                        // Zero shortcut: the answer is known without iterating.
                        result_d = '0;
                        ovf_d    = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (b_q[0]) begin
                    prod_d = prod_q + addend;
                end
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = prod_signed[W-1:0];
                ovf_d    = ovf_fix;
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign result    = result_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
    import mult_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT W=16 ----------------
    logic        start16;
    logic [15:0] a16, b16, res16;
    logic        ovf16, busy16, done16;
    state_t      st16;

    seq_multiplier #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op_a(a16), .op_b(b16),
        .result(res16), .ovf(ovf16), .busy(busy16), .done(done16), .dbg_state(st16)
    );

    // ---------------- DUT W=8 ----------------
    logic       start8;
    logic [7:0] a8, b8, res8;
    logic       ovf8, busy8, done8;
    state_t     st8;

    seq_multiplier #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op_a(a8), .op_b(b8),
        .result(res8), .ovf(ovf8), .busy(busy8), .done(done8), .dbg_state(st8)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-precision signed product, then truncate / range test.
    function automatic void model(input int w, input longint sa, input longint sb,
                                  output logic [63:0] r, output logic o);
        longint p;
        longint lim;
        p   = sa * sb;
        lim = longint'(1) <<< (w - 1);
        r   = 64'(p) & ((64'd1 << w) - 64'd1);
        o   = (p >= lim) || (p < -lim);
    endfunction

    // ---------------- drivers ----------------
    // Called just after a negedge. Returns at the negedge where done is seen.
    // lat = number of edges from the accepting edge to done, inclusive.
    task automatic mul16(input logic [15:0] a, input logic [15:0] b, input int poke_at,
                         output int lat, output bit busy_ok);
        start16 = 1'b1; a16 = a; b16 = b;
        @(posedge clk); #1;
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0; busy_ok = 1'b1;
        @(negedge clk);
        while (!done16 && lat < 60) begin
            if (!busy16) busy_ok = 1'b0;
            lat++;
            if (lat == poke_at) begin
                start16 = 1'b1; a16 = 16'd9; b16 = 16'd9;
            end else begin
                start16 = 1'b0;
            end
            @(negedge clk);
        end
        if (busy16) busy_ok = 1'b0;
        lat = lat + 1;
        start16 = 1'b0;
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output bit busy_ok);
        start8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0; busy_ok = 1'b1;
        @(negedge clk);
        while (!done8 && lat < 60) begin
            if (!busy8) busy_ok = 1'b0;
            lat++;
            @(negedge clk);
        end
        if (busy8) busy_ok = 1'b0;
        lat = lat + 1;
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_r, input logic exp_o, input int exp_lat,
                         input int poke_at);
        int lat;
        bit bok;
        mul16(a, b, poke_at, lat, bok);
        check({tag, "_res"}, res16, exp_r);
        check({tag, "_ovf"}, ovf16, exp_o);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, bok, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    int          lat, dcnt, chg;
    bit          bok;
    logic [63:0] er;
    logic        eo;
    logic [15:0] ra16, rb16;
    logic [7:0]  ra8, rb8;

    initial begin
        rst = 1'b1; start16 = 1'b0; start8 = 1'b0;
        a16 = '0; b16 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res16", res16, 16'd0);
        check("rst_ovf16", ovf16, 1'b0);
        check("rst_busy16", busy16, 1'b0);
        check("rst_done16", done16, 1'b0);
        check("rst_state16", 64'(st16), 64'(ST_IDLE));
        check("rst_res8", res8, 8'd0);
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 3 x 5 with a start pulse (9 x 9) injected during CALC
        run16("mul_3x5", 16'd3, 16'd5, 16'd15, 1'b0, 18, 3);
        dcnt = 0; chg = 0;
        repeat (25) begin
            @(negedge clk);
            if (done16) dcnt++;
            if (res16 !== 16'd15) chg++;
        end
        check("single_done", dcnt, 0);
        check("res_stable", chg, 0);

        run16("mul_m7x6", 16'hFFF9, 16'd6, 16'hFFD6, 1'b0, 18, -1);
        run16("mul_m256x128", 16'hFF00, 16'd128, 16'h8000, 1'b0, 18, -1);
        run16("mul_300x300", 16'd300, 16'd300, 16'd24464, 1'b1, 18, -1);
        run16("mul_min_x_m1", 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 18, -1);
        run16("zero_0x1234", 16'd0, 16'd1234, 16'd0, 1'b0, 1, -1);
        // back-to-back: issued from the DONE cycle of the zero shortcut
        run16("b2b_2x2", 16'd2, 16'd2, 16'd4, 1'b0, 18, -1);
        @(negedge clk);
        check("done_width", done16, 1'b0);

        // reset 7 cycles into a multiply
        start16 = 1'b1; a16 = 16'd100; b16 = 16'd3;
        @(posedge clk); #1;
        start16 = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", busy16, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_res", res16, 16'd0);
        check("midrst_ovf", ovf16, 1'b0);
        check("midrst_busy", busy16, 1'b0);
        check("midrst_done", done16, 1'b0);
        rst = 1'b0;
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done16) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        run16("mul_4xm4", 16'd4, 16'hFFFC, 16'hFFF0, 1'b0, 18, -1);

        // reset and start on the same edge: reset wins
        rst = 1'b1; start16 = 1'b1; a16 = 16'd5; b16 = 16'd5;
        @(negedge clk);
        check("rststart_res", res16, 16'd0);
        check("rststart_busy", busy16, 1'b0);
        rst = 1'b0; start16 = 1'b0;
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done16) dcnt++;
        end
        check("rststart_no_done", dcnt, 0);

        // random W=16
        for (int i = 0; i < 1000; i++) begin
            ra16 = 16'($urandom);
            rb16 = 16'($urandom);
            if ($urandom_range(0, 15) == 0) ra16 = '0;
            if ($urandom_range(0, 15) == 0) rb16 = '0;
            model(16, longint'($signed(ra16)), longint'($signed(rb16)), er, eo);
            mul16(ra16, rb16, -1, lat, bok);
            check("rnd16_res", res16, er);
            check("rnd16_ovf", ovf16, eo);
            check("rnd16_lat", lat, (ra16 == 0 || rb16 == 0) ? 1 : 18);
            check("rnd16_busy", bok, 1'b1);
            @(negedge clk);
            check("rnd16_done_width", done16, 1'b0);
        end

        // random W=8
        for (int i = 0; i < 1000; i++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            if ($urandom_range(0, 15) == 0) ra8 = '0;
            if ($urandom_range(0, 15) == 0) rb8 = '0;
            model(8, longint'($signed(ra8)), longint'($signed(rb8)), er, eo);
            mul8(ra8, rb8, lat, bok);
            check("rnd8_res", res8, er);
            check("rnd8_ovf", ovf8, eo);
            check("rnd8_lat", lat, (ra8 == 0 || rb8 == 0) ? 1 : 10);
            check("rnd8_busy", bok, 1'b1);
            @(negedge clk);
            check("rnd8_done_width", done8, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
